// File: rtl/core_run_ctrl_pkg.sv
// Shared types and constants for the core run controller: state encoding,
// the default halt instruction and the reset values of the control outputs.
package core_run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } run_state_t;

    // addi x0,x0,0 -- the canonical RISC-V nop, used as the end-of-program marker
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam run_state_t RST_STATE      = S_IDLE;
    localparam logic       RST_CORE_RESET = 1'b0;
    localparam logic       RST_FLAG       = 1'b0;

endpackage

// File: rtl/core_run_ctrl_halt_detect.sv
// Consecutive halt-instruction detector: halt pulses combinationally on the
// HALT_COUNT-th back-to-back match while enabled; the count clears when disabled.
module halt_detect
    import core_run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = NOP_INSTR,
    parameter int unsigned HALT_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] instr,
    output logic        halt
);

    logic [3:0] cnt_q, cnt_d;
    logic       match;

    assign match = (instr == HALT_INSTR);
    assign halt  = en && match && (cnt_q == 4'(HALT_COUNT - 1));

    always_comb begin
        cnt_d = '0;
        if (en && match) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: streams a program into imem, holds the core in reset, runs it
// until a halt pattern or timeout. CORE_RUN_CTRL_STATS_EN enables fetch_count.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] HALT_INSTR = NOP_INSTR,
    parameter int unsigned HALT_COUNT = 4,
    parameter int unsigned RST_HOLD   = 2,
    parameter int unsigned CYC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    input  logic [31:0]           fetch_instr,
    input  logic [CYC_WIDTH-1:0]  timeout_cycles,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  load_overflow,
    output logic [CYC_WIDTH-1:0]  cycle_count,
    output logic [CYC_WIDTH-1:0]  fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CYC_WIDTH-1:0]  CYC_MAX  = '1;
    localparam logic [CYC_WIDTH-1:0]  CYC_ONE  = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

    run_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            hold_q, hold_d;
    logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
    logic                  core_rst_q, core_rst_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic                  ovf_q, ovf_d;
    logic                  run_en, halt, tmo_hit;

    assign run_en = (state_q == S_RUN);

    halt_detect #(
        .HALT_INSTR (HALT_INSTR),
        .HALT_COUNT (HALT_COUNT)
    ) u_halt_detect (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .instr (fetch_instr),
        .halt  (halt)
    );

    // Widened compare so a saturated counter cannot alias onto a small limit.
    assign tmo_hit = (timeout_cycles != '0) &&
                     (({1'b0, cyc_q} + {{CYC_WIDTH{1'b0}}, 1'b1}) == {1'b0, timeout_cycles});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = '0;
        cyc_d   = cyc_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        ovf_d   = ovf_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        addr_d  = '0;
                        cyc_d   = '0;
                        done_d  = 1'b0;
                        tmo_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        if (addr_q != ADDR_MAX) begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                        if (load_last) begin
                            state_d = S_HOLD;
                        end else if (addr_q == ADDR_MAX) begin
                            ovf_d   = 1'b1;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == 4'(RST_HOLD - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                S_RUN: begin
                    if (cyc_q != CYC_MAX) begin
                        cyc_d = cyc_q + CYC_ONE;
                    end
                    if (halt) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (tmo_hit) begin
                        state_d = S_DONE;
                        tmo_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        core_rst_d = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RST_STATE;
            addr_q     <= '0;
            hold_q     <= '0;
            cyc_q      <= '0;
            core_rst_q <= RST_CORE_RESET;
            done_q     <= RST_FLAG;
            tmo_q      <= RST_FLAG;
            ovf_q      <= RST_FLAG;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            cyc_q      <= cyc_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef CORE_RUN_CTRL_STATS_EN
    logic [CYC_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                 stats_clr, stats_step;

    assign stats_clr  = !abort && start && (state_q == S_IDLE || state_q == S_DONE);
    assign stats_step = !abort && run_en && (fetch_instr != HALT_INSTR);

    always_comb begin
        fcnt_d = fcnt_q;
        if (stats_clr) begin
            fcnt_d = '0;
        end else if (stats_step && fcnt_q != CYC_MAX) begin
            fcnt_d = fcnt_q + CYC_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign fetch_count = fcnt_q;
`else
    assign fetch_count = '0;
`endif

    assign load_ready    = (state_q == S_LOAD);
    assign imem_we       = load_ready && load_valid;
    assign imem_addr     = addr_q;
    assign imem_wdata    = load_ready ? load_data : '0;
    assign core_reset    = core_rst_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_HOLD) || run_en;
    assign done          = done_q;
    assign timed_out     = tmo_q;
    assign load_overflow = ovf_q;
    assign cycle_count   = cyc_q;

endmodule
